systolic_input_skewer: RTL

Upstream feeder for a row of processing elements in the systolic array. Accepts one LANES-wide input vector per handshake and re-times it into a diagonal wavefront: lane i is delayed by i advances, so each PE row sees its operand one cycle after the row above. It generates the shared array enable. After the last vector it injects zero vectors until the wavefront and partial sums have drained, then pulses DONE.

---
 rtl/systolic_input_skewer.sv | 94 +++++++++
 1 files changed

// File: rtl/systolic_input_skewer.sv
// systolic_input_skewer: re-times LANES-wide vectors into a diagonal wavefront (lane i delayed by i advances),
// drives the shared array enable and zero-flushes the array after the last vector of a tile.
module systolic_input_skewer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DRAIN = 4
) (
    input  logic                   CLK,
    input  logic                   ASYNC_RST,
    input  logic                   SYNC_RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_LAST,
    output logic [LANES*WIDTH-1:0] OUT_DATA,
    output logic                   OUT_EN,
    output logic                   BUSY,
    output logic                   DONE
);
    localparam int CW = $clog2(LANES + DRAIN);
    localparam logic [1:0] S_IDLE = 2'd0, S_STREAM = 2'd1, S_FLUSH = 2'd2;
    localparam logic [CW-1:0] FLUSH_LEN = CW'(LANES - 1 + DRAIN);

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   en_q, done_q, done_d, flushing, accept, adv;
    logic [LANES*WIDTH-1:0] inj;

    assign flushing = state_q == S_FLUSH;
    assign IN_READY = !flushing;
    assign accept   = IN_VALID & IN_READY;
    assign adv      = accept | flushing;
    assign inj      = accept ? IN_DATA : '0;
    assign done_d   = flushing && cnt_q == CW'(1);
    assign OUT_EN   = en_q;
    assign DONE     = done_q;
    assign BUSY     = state_q != S_IDLE;

    always_comb begin
        state_d = flushing ? (done_d ? S_IDLE : S_FLUSH)
                : accept ? (IN_LAST ? S_FLUSH : S_STREAM) : state_q;
        cnt_d   = flushing ? cnt_q - CW'(1) : (accept && IN_LAST) ? FLUSH_LEN : cnt_q;
    end

    always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (SYNC_RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= adv;
            done_q  <= done_d;
        end
    end

    // Chains shift only on advance so bubbles never break wavefront alignment.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] out_q;
        logic [WIDTH-1:0] inj_l;
        assign inj_l = inj[i*WIDTH +: WIDTH];
        assign OUT_DATA[i*WIDTH +: WIDTH] = out_q;
        if (i == 0) begin : g_head
            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) out_q <= '0;
                else if (SYNC_RST) out_q <= '0;
                else if (adv) out_q <= inj_l;
            end
        end else begin : g_chain
            logic [i*WIDTH-1:0]     ch_q;
            logic [(i+1)*WIDTH-1:0] cat;
            assign cat = {ch_q, inj_l};
            always_ff @(posedge CLK or negedge ASYNC_RST) begin
                if (!ASYNC_RST) begin
                    out_q <= '0;
                    ch_q  <= '0;
                end else if (SYNC_RST) begin
                    out_q <= '0;
                    ch_q  <= '0;
                end else if (adv) begin
                    out_q <= cat[(i+1)*WIDTH-1 -: WIDTH];
                    ch_q  <= cat[i*WIDTH-1:0];
                end
            end
        end
    end
endmodule
